instruction_encoder: RTL and testbench

INSTRUCTION_ENCODER -- requirements
Module: instruction_encoder

---
 rtl/instruction_encoder.sv | 169 ++++++++++++++++
 tb/tb_instruction_encoder.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_encoder.sv
// Instruction encoder: packs decoded field sets into 32-bit words and streams them into instruction memory.
// Words reach the memory port one cycle after transfer; in_ready drops only when the word FIFO is full.

module enc_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_vld,
  output logic         wr_rdy,
  input  logic [W-1:0] wr_dat,
  output logic         rd_vld,
  input  logic         rd_rdy,
  output logic [W-1:0] rd_dat
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push;
  logic             pop;

  // wr_rdy looks only at occupancy, so a pop on the same edge never admits an extra push
  assign wr_rdy = (count < CNT_W'(DEPTH));
  assign rd_vld = (count != '0);
  assign rd_dat = mem[rd_ptr];
  assign push   = wr_vld && wr_rdy;
  assign pop    = rd_vld && rd_rdy;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst) mem[wr_ptr] <= wr_dat;
  end
endmodule

module instruction_encoder #(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        ALUop,
  input  logic [4:0]        rd,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [31:0]       immediate,
  input  logic              isImmediateOp,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  output logic              err,
  output logic [7:0]        err_count,
  output logic              wrapped
);
  typedef struct packed {
    logic [3:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [12:0] imm;
  } insn_t;

  logic [3:0]  opcode;
  logic        is_rtype;
  logic        is_itype;
  logic        bad_op;
  logic        imm_fits;
  logic        reject;
  logic        xfer;
  insn_t       word;
  logic        fifo_wr_vld;
  logic        fifo_rd_vld;
  logic [31:0] fifo_rd_dat;

  always_comb begin
    opcode   = 4'd0;
    is_rtype = 1'b0;
    is_itype = 1'b0;
    bad_op   = 1'b0;
    case (ALUop)
      3'b000: opcode = 4'd0;
      3'b001: bad_op = 1'b1;
      3'b010: begin opcode = 4'd1; is_rtype = 1'b1; end
      3'b011: begin opcode = 4'd2; is_rtype = 1'b1; end
      3'b100: begin opcode = 4'd3; is_rtype = 1'b1; end
      3'b101: begin opcode = 4'd4; is_rtype = 1'b1; end
      3'b110: begin opcode = 4'd5; is_itype = 1'b1; end
      3'b111: begin opcode = 4'd6; is_itype = 1'b1; end
      default: bad_op = 1'b1;
    endcase
  end

  // the immediate fits 13 bits signed when bits [31:12] are all copies of bit 12
  assign imm_fits = (immediate[31:12] == {20{immediate[12]}});

  assign reject = bad_op
               || (isImmediateOp && !is_itype)
               || (!isImmediateOp && is_itype)
               || (is_itype && !imm_fits);

  always_comb begin
    word = '0;
    if (is_rtype || is_itype) begin
      word.opcode = opcode;
      word.rd     = rd;
      word.rs1    = rs1;
      if (is_rtype) word.rs2 = rs2;
      if (is_itype) word.imm = immediate[12:0];
    end
  end

  assign xfer        = in_valid && in_ready;
  assign fifo_wr_vld = in_valid && !reject;

  enc_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (32)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .wr_vld (fifo_wr_vld),
    .wr_rdy (in_ready),
    .wr_dat (word),
    .rd_vld (fifo_rd_vld),
    .rd_rdy (mem_ready),
    .rd_dat (fifo_rd_dat)
  );

  assign mem_we    = fifo_rd_vld && mem_ready;
  assign mem_wdata = fifo_rd_dat;

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_addr  <= '0;
      wrapped   <= 1'b0;
      err       <= 1'b0;
      err_count <= 8'd0;
    end else begin
      if (mem_we) begin
        mem_addr <= mem_addr + ADDR_W'(1);
        if (&mem_addr) wrapped <= 1'b1;
      end
      err <= xfer && reject;
      if (xfer && reject && (err_count != 8'hFF)) err_count <= err_count + 8'd1;
    end
  end
endmodule

// File: tb/tb_instruction_encoder.sv
// Bench for instruction_encoder: fixed vectors, directed corner sequences and a random run checked by a queue model.
module tb_instruction_encoder;
  localparam int DEPTH = 4;
  localparam int AW    = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [2:0]    ALUop = 3'd0;
  logic [4:0]    rd = 5'd0;
  logic [4:0]    rs1 = 5'd0;
  logic [4:0]    rs2 = 5'd0;
  logic [31:0]   immediate = 32'd0;
  logic          isImmediateOp = 1'b0;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          mem_ready = 1'b0;
  logic          err;
  logic [7:0]    err_count;
  logic          wrapped;

  instruction_encoder #(.FIFO_DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .ALUop(ALUop), .rd(rd), .rs1(rs1), .rs2(rs2), .immediate(immediate),
    .isImmediateOp(isImmediateOp), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .err(err),
    .err_count(err_count), .wrapped(wrapped)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // reference model state
  logic [31:0] mq[$];
  int          m_addr;
  bit          m_wrapped;
  bit          m_err;
  int          m_cnt;
  int          opc_tab[8];
  logic [31:0] obs_addr[$];
  logic [31:0] obs_data[$];
  int          n_err_pulses;

  typedef struct {
    logic [2:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        isimm;
    logic        rej;
    logic [31:0] word;
  } vec_t;
  vec_t vt[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit ref_reject(input logic [2:0] op, input logic isimm, input logic [31:0] imm);
    int simm;
    bit itype;
    simm  = $signed(imm);
    itype = (op == 3'd6) || (op == 3'd7);
    if (op == 3'd1) return 1'b1;
    if (isimm != itype) return 1'b1;
    if (itype && (simm < -4096 || simm > 4095)) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] ref_word(input logic [2:0] op, input logic [4:0] frd,
                                           input logic [4:0] frs1, input logic [4:0] frs2,
                                           input logic [31:0] imm);
    longint w;
    int simm;
    if (op == 3'd0) return 32'd0;
    simm = $signed(imm);
    w = longint'(opc_tab[op]) * (2**28) + longint'(frd) * (2**23) + longint'(frs1) * (2**18);
    if (op >= 3'd6) w += longint'(((simm % 8192) + 8192) % 8192);
    else            w += longint'(frs2) * (2**13);
    return 32'(w);
  endfunction

  task automatic model_clear();
    mq.delete();
    m_addr = 0;
    m_wrapped = 1'b0;
    m_err = 1'b0;
    m_cnt = 0;
  endtask

  // One clock: check outputs against the model, then advance the model across the edge.
  task automatic cycle(output bit took);
    bit tr, pop, rj;
    logic [31:0] w;
    #1;
    chk("in_ready", 32'(in_ready), 32'(mq.size() < DEPTH));
    chk("mem_we", 32'(mem_we), 32'(mq.size() > 0 && mem_ready));
    if (mq.size() > 0 && mem_ready) chk("mem_wdata", mem_wdata, mq[0]);
    chk("mem_addr", 32'(mem_addr), 32'(m_addr));
    chk("err", 32'(err), 32'(m_err));
    chk("err_count", 32'(err_count), 32'(m_cnt));
    chk("wrapped", 32'(wrapped), 32'(m_wrapped));
    if (mem_we === 1'b1) begin
      obs_addr.push_back(32'(mem_addr));
      obs_data.push_back(mem_wdata);
    end
    if (err === 1'b1) n_err_pulses++;
    tr   = in_valid && (mq.size() < DEPTH);
    pop  = (mq.size() > 0) && mem_ready;
    rj   = ref_reject(ALUop, isImmediateOp, immediate);
    w    = ref_word(ALUop, rd, rs1, rs2, immediate);
    took = tr && !rst;
    @(posedge clk);
    if (rst) begin
      model_clear();
    end else begin
      if (pop) begin
        void'(mq.pop_front());
        if (m_addr == (1 << AW) - 1) begin
          m_addr = 0;
          m_wrapped = 1'b1;
        end else begin
          m_addr++;
        end
      end
      m_err = tr && rj;
      if (tr && rj && m_cnt < 255) m_cnt++;
      if (tr && !rj) mq.push_back(w);
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_clear();
  endtask

  task automatic set_fields(input logic [2:0] op, input logic [4:0] frd, input logic [4:0] frs1,
                            input logic [4:0] frs2, input logic [31:0] imm, input logic isimm);
    ALUop = op; rd = frd; rs1 = frs1; rs2 = frs2; immediate = imm; isImmediateOp = isimm;
  endtask

  task automatic rand_fields(input bit legal);
    int t;
    int simm;
    if (legal) begin
      t = $urandom_range(0, 6);
      ALUop = 3'((t == 0) ? 0 : t + 1);
    end else begin
      ALUop = 3'($urandom_range(0, 7));
    end
    rd  = 5'($urandom);
    rs1 = 5'($urandom);
    rs2 = 5'($urandom);
    isImmediateOp = (ALUop >= 3'd6);
    if (!legal && $urandom_range(0, 9) == 0) isImmediateOp = ~isImmediateOp;
    simm = int'($urandom_range(0, 8191)) - 4096;
    immediate = 32'(simm);
    if (!legal && $urandom_range(0, 4) == 0) immediate = $urandom;
  endtask

  bit t;
  int n_rej;
  int n_acc;
  int iters;

  initial begin
    opc_tab = '{0, -1, 1, 2, 3, 4, 5, 6};
    vt[0]  = '{3'b010, 5'd3,  5'd1,  5'd2,  32'h00000000, 1'b0, 1'b0, 32'h11844000};
    vt[1]  = '{3'b110, 5'd5,  5'd5,  5'd0,  32'hFFFFFFFF, 1'b1, 1'b0, 32'h52941FFF};
    vt[2]  = '{3'b110, 5'd5,  5'd5,  5'd0,  32'h00001000, 1'b1, 1'b1, 32'h00000000};
    vt[3]  = '{3'b000, 5'd31, 5'd31, 5'd31, 32'h00000005, 1'b0, 1'b0, 32'h00000000};
    vt[4]  = '{3'b011, 5'd1,  5'd2,  5'd3,  32'h00007FFF, 1'b0, 1'b0, 32'h20886000};
    vt[5]  = '{3'b100, 5'd31, 5'd0,  5'd31, 32'h00000000, 1'b0, 1'b0, 32'h3F83E000};
    vt[6]  = '{3'b101, 5'd0,  5'd31, 5'd0,  32'h00000000, 1'b0, 1'b0, 32'h407C0000};
    vt[7]  = '{3'b111, 5'd2,  5'd3,  5'd9,  32'h00000FFF, 1'b1, 1'b0, 32'h610C0FFF};
    vt[8]  = '{3'b110, 5'd0,  5'd0,  5'd0,  32'hFFFFF000, 1'b1, 1'b0, 32'h50001000};
    vt[9]  = '{3'b111, 5'd1,  5'd1,  5'd1,  32'hFFFFEFFF, 1'b1, 1'b1, 32'h00000000};
    vt[10] = '{3'b001, 5'd1,  5'd1,  5'd1,  32'h00000000, 1'b0, 1'b1, 32'h00000000};
    vt[11] = '{3'b010, 5'd1,  5'd1,  5'd1,  32'h00000000, 1'b1, 1'b1, 32'h00000000};
    vt[12] = '{3'b110, 5'd1,  5'd1,  5'd1,  32'h00000000, 1'b0, 1'b1, 32'h00000000};
    vt[13] = '{3'b000, 5'd0,  5'd0,  5'd0,  32'h00000000, 1'b1, 1'b1, 32'h00000000};
    vt[14] = '{3'b101, 5'd7,  5'd7,  5'd7,  32'hFFFFFFFF, 1'b0, 1'b0, 32'h439CE000};

    // reset state
    mem_ready = 1'b1;
    do_reset();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_err_count", 32'(err_count), 32'd0);
    chk("rst_wrapped", 32'(wrapped), 32'd0);

    // fixed encoding vectors, one transfer each
    n_rej = 0;
    foreach (vt[i]) begin
      set_fields(vt[i].op, vt[i].rd, vt[i].rs1, vt[i].rs2, vt[i].imm, vt[i].isimm);
      in_valid = 1'b1;
      cycle(t);
      in_valid = 1'b0;
      if (vt[i].rej) begin
        n_rej++;
        chk($sformatf("vec%0d_err", i), 32'(err), 32'd1);
        chk($sformatf("vec%0d_no_we", i), 32'(mem_we), 32'd0);
      end else begin
        chk($sformatf("vec%0d_we", i), 32'(mem_we), 32'd1);
        chk($sformatf("vec%0d_word", i), mem_wdata, vt[i].word);
      end
      chk($sformatf("vec%0d_err_count", i), 32'(err_count), 32'(n_rej));
      cycle(t);
    end

    // back-pressure: four fill the FIFO, the fifth waits for memory
    do_reset();
    mem_ready = 1'b0;
    obs_addr.delete(); obs_data.delete();
    for (int i = 0; i < 4; i++) begin
      set_fields(3'b010, 5'(i + 1), 5'd1, 5'd2, 32'd0, 1'b0);
      in_valid = 1'b1;
      cycle(t);
      chk("bp_take", 32'(t), 32'd1);
    end
    set_fields(3'b010, 5'd5, 5'd1, 5'd2, 32'd0, 1'b0);
    #1;
    chk("bp_full_in_ready", 32'(in_ready), 32'd0);
    cycle(t);
    cycle(t);
    chk("bp_hold_no_take", 32'(t), 32'd0);
    chk("bp_hold_no_write", 32'(obs_addr.size()), 32'd0);
    mem_ready = 1'b1;
    iters = 0;
    t = 1'b0;
    while (!t && iters < 10) begin
      cycle(t);
      iters++;
    end
    chk("bp_fifth_taken", 32'(t), 32'd1);
    chk("bp_fifth_delay", 32'(iters), 32'd2);
    in_valid = 1'b0;
    for (int i = 0; i < 6; i++) cycle(t);
    chk("bp_writes", 32'(obs_addr.size()), 32'd5);
    for (int i = 0; i < 5 && i < obs_addr.size(); i++) begin
      chk($sformatf("bp_addr%0d", i), obs_addr[i], 32'(i));
      chk($sformatf("bp_data%0d", i), obs_data[i], 32'h10044000 + 32'((i + 1) * (2**23)));
    end

    // rejection matrix
    do_reset();
    mem_ready = 1'b1;
    obs_addr.delete(); obs_data.delete();
    n_err_pulses = 0;
    in_valid = 1'b1;
    set_fields(3'b001, 5'd1, 5'd2, 5'd3, 32'd0, 1'b0); cycle(t);
    set_fields(3'b010, 5'd1, 5'd2, 5'd3, 32'd0, 1'b1); cycle(t);
    set_fields(3'b111, 5'd1, 5'd2, 5'd3, 32'd4, 1'b0); cycle(t);
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) cycle(t);
    chk("rej_pulses", 32'(n_err_pulses), 32'd3);
    chk("rej_err_count", 32'(err_count), 32'd3);
    chk("rej_no_write", 32'(obs_addr.size()), 32'd0);

    // reset with three words buffered and a transfer in flight
    do_reset();
    mem_ready = 1'b1;
    in_valid = 1'b1;
    set_fields(3'b001, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0); cycle(t);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_fields(3'b011, 5'(i), 5'd4, 5'd5, 32'd0, 1'b0);
      cycle(t);
    end
    chk("mid_err_count_pre", 32'(err_count), 32'd1);
    rst = 1'b1;
    cycle(t);
    rst = 1'b0;
    in_valid = 1'b0;
    mem_ready = 1'b1;
    obs_addr.delete(); obs_data.delete();
    #1;
    chk("mid_mem_we", 32'(mem_we), 32'd0);
    chk("mid_in_ready", 32'(in_ready), 32'd1);
    chk("mid_mem_addr", 32'(mem_addr), 32'd0);
    chk("mid_err_count", 32'(err_count), 32'd0);
    for (int i = 0; i < 3; i++) cycle(t);
    chk("mid_no_write", 32'(obs_addr.size()), 32'd0);

    // address wrap after 256 words
    do_reset();
    mem_ready = 1'b1;
    obs_addr.delete(); obs_data.delete();
    n_acc = 0;
    iters = 0;
    in_valid = 1'b1;
    while (n_acc < 256 && iters < 2000) begin
      rand_fields(1'b1);
      cycle(t);
      if (t) n_acc++;
      iters++;
    end
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) cycle(t);
    chk("wrap_accepted", 32'(n_acc), 32'd256);
    chk("wrap_writes", 32'(obs_addr.size()), 32'd256);
    if (obs_addr.size() > 0) chk("wrap_last_addr", obs_addr[obs_addr.size() - 1], 32'd255);
    chk("wrap_mem_addr", 32'(mem_addr), 32'd0);
    chk("wrap_flag", 32'(wrapped), 32'd1);

    // err_count saturation
    do_reset();
    in_valid = 1'b1;
    set_fields(3'b001, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0);
    for (int i = 0; i < 260; i++) cycle(t);
    in_valid = 1'b0;
    cycle(t);
    chk("sat_err_count", 32'(err_count), 32'd255);

    // random traffic against the model
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      mem_ready = ($urandom_range(0, 9) < 6);
      rst       = ($urandom_range(0, 299) == 0);
      rand_fields($urandom_range(0, 3) != 0);
      cycle(t);
    end
    rst = 1'b0;
    in_valid = 1'b0;
    mem_ready = 1'b1;
    for (int i = 0; i < 8; i++) cycle(t);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
